// File: rtl/adder_pkg.sv
// Segment geometry helpers shared by the carry-segmented adder and its users.
// Segment s of a WIDTH-bit word split STAGES ways covers [seg_lo, seg_lo+seg_len-1].
package adder_pkg;

    localparam int MIN_STAGES = 1;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int seg_lo(input int width, input int stages, input int s);
        return s * seg_width(width, stages);
    endfunction

    // Ceil-sized segments can leave trailing stages with nothing to add; those report 0.
    function automatic int seg_len(input int width, input int stages, input int s);
        int lo;
        int hi;
        lo = seg_lo(width, stages, s);
        hi = (s + 1) * seg_width(width, stages);
        if (hi > width) hi = width;
        return (hi > lo) ? (hi - lo) : 0;
    endfunction

    function automatic bit stages_legal(input int width, input int stages);
        return (stages >= MIN_STAGES) && (stages <= width);
    endfunction

endpackage

// File: rtl/n_bit_adder_if.sv
// Operand/result bundle of one adder cell; master drives operands, slave returns the sum.
interface n_bit_adder_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             cin;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, input1, input2, cin,
        input  out, cout, ovf, out_valid
    );

    modport slave (
        input  in_valid, input1, input2, cin,
        output out, cout, ovf, out_valid
    );

endinterface

// File: rtl/adder_segment.sv
// Combinational W-bit full adder: one carry-chain segment of the pipelined adder.
module adder_segment #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s     = total[W-1:0];
    assign co    = total[W];

endmodule

// File: rtl/n_bit_adder.sv
// Registered two-operand adder whose carry chain is cut into STAGES registered segments.
// Operands are skewed forward and partial sums deskewed so every result bit leaves together.
module n_bit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    n_bit_adder_if.slave     bus
);

    localparam int LAST = STAGES - 1;

    if (!stages_legal(WIDTH, STAGES)) begin : g_bad_param
        $error("n_bit_adder: STAGES must lie in 1..WIDTH");
    end

    logic [STAGES-1:0][WIDTH-1:0] a_pipe;
    logic [STAGES-1:0][WIDTH-1:0] b_pipe;
    logic [STAGES-1:0][WIDTH-1:0] sum_pipe;
    logic [STAGES-1:0]            carry_pipe;
    logic [STAGES-1:0]            vld_pipe;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO  = seg_lo(WIDTH, STAGES, s);
        localparam int LEN = seg_len(WIDTH, STAGES, s);

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             ci_in;
        logic             vld_in;

        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_d;
        logic [WIDTH-1:0] sum_d;
        logic             carry_d;
        logic             vld_d;

        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             vld_q;

        if (s == 0) begin : g_first
            assign a_in   = bus.input1;
            assign b_in   = bus.input2;
            assign sum_in = '0;
            assign ci_in  = bus.cin;
            assign vld_in = bus.in_valid;
        end else begin : g_next
            assign a_in   = a_pipe[s-1];
            assign b_in   = b_pipe[s-1];
            assign sum_in = sum_pipe[s-1];
            assign ci_in  = carry_pipe[s-1];
            assign vld_in = vld_pipe[s-1];
        end

        if (LEN > 0) begin : g_add
            logic [LEN-1:0] seg_sum;
            logic           seg_co;

            adder_segment #(
                .W (LEN)
            ) u_seg (
                .a  (a_in[LO +: LEN]),
                .b  (b_in[LO +: LEN]),
                .ci (ci_in),
                .s  (seg_sum),
                .co (seg_co)
            );

            always_comb begin
                sum_d              = sum_in;
                sum_d[LO +: LEN]   = seg_sum;
                carry_d            = seg_co;
            end
        end else begin : g_pass
            // Nothing left to add in this stage: it only adds a cycle of delay.
            always_comb begin
                sum_d   = sum_in;
                carry_d = ci_in;
            end
        end

        // Operands ride along untouched; the upper bits feed later segments, the MSBs feed ovf.
        assign a_d   = a_in;
        assign b_d   = b_in;
        assign vld_d = vld_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q     <= '0;
                b_q     <= '0;
                sum_q   <= '0;
                carry_q <= 1'b0;
                vld_q   <= 1'b0;
            end else begin
                a_q     <= a_d;
                b_q     <= b_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
                vld_q   <= vld_d;
            end
        end

        assign a_pipe[s]     = a_q;
        assign b_pipe[s]     = b_q;
        assign sum_pipe[s]   = sum_q;
        assign carry_pipe[s] = carry_q;
        assign vld_pipe[s]   = vld_q;
    end

    assign bus.out       = sum_pipe[LAST];
    assign bus.cout      = carry_pipe[LAST];
    assign bus.out_valid = vld_pipe[LAST];

    // Reset leaves all operand and sum bits at zero, so ovf also reads 0 under reset.
    assign bus.ovf = (a_pipe[LAST][WIDTH-1] == b_pipe[LAST][WIDTH-1]) &&
                     (sum_pipe[LAST][WIDTH-1] != a_pipe[LAST][WIDTH-1]);

endmodule

// File: tb/tb_n_bit_adder.sv
// Drives one operand stream into 8-bit adders built with STAGES = 1, 4 and 8 and
// compares each against an arithmetic model delayed by that instance's latency.
module tb_n_bit_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       drv_valid;
    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic       drv_cin;

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int last_rst_cyc = 0;

    logic       hv [0:4095];
    logic [8:0] hs [0:4095];
    logic       ho [0:4095];

    always #5 clk = ~clk;

    n_bit_adder_if #(.WIDTH(8)) bus1 ();
    n_bit_adder_if #(.WIDTH(8)) bus4 ();
    n_bit_adder_if #(.WIDTH(8)) bus8 ();

    assign bus1.in_valid = drv_valid;
    assign bus1.input1   = drv_a;
    assign bus1.input2   = drv_b;
    assign bus1.cin      = drv_cin;
    assign bus4.in_valid = drv_valid;
    assign bus4.input1   = drv_a;
    assign bus4.input2   = drv_b;
    assign bus4.cin      = drv_cin;
    assign bus8.in_valid = drv_valid;
    assign bus8.input1   = drv_a;
    assign bus8.input2   = drv_b;
    assign bus8.cin      = drv_cin;

    n_bit_adder #(.WIDTH(8), .STAGES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    n_bit_adder #(.WIDTH(8), .STAGES(4)) u_s4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    n_bit_adder #(.WIDTH(8), .STAGES(8)) u_s8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string name, input int lat, input logic [7:0] o,
                             input logic co, input logic ov, input logic v);
        int idx;
        idx = cyc - lat;
        if (!rst_n) begin
            check({name, "_rst_out"},   int'(o),  0);
            check({name, "_rst_cout"},  int'(co), 0);
            check({name, "_rst_ovf"},   int'(ov), 0);
            check({name, "_rst_valid"}, int'(v),  0);
        end else if (idx > last_rst_cyc && hv[idx]) begin
            check({name, "_valid"}, int'(v),  1);
            check({name, "_out"},   int'(o),  int'(hs[idx][7:0]));
            check({name, "_cout"},  int'(co), int'(hs[idx][8]));
            check({name, "_ovf"},   int'(ov), int'(ho[idx]));
        end else begin
            check({name, "_idle_valid"}, int'(v), 0);
        end
    endtask

    // One rising edge: log what was sampled, then look at every instance 1 ns later.
    task automatic tick();
        int total;
        int stotal;
        @(posedge clk);
        cyc++;
        total   = int'(drv_a) + int'(drv_b) + int'(drv_cin);
        stotal  = int'($signed(drv_a)) + int'($signed(drv_b)) + int'(drv_cin);
        hv[cyc] = drv_valid && rst_n;
        hs[cyc] = total[8:0];
        ho[cyc] = (stotal > 127) || (stotal < -128);
        #1;
        check_dut("s1", 0, bus1.out, bus1.cout, bus1.ovf, bus1.out_valid);
        check_dut("s4", 3, bus4.out, bus4.cout, bus4.ovf, bus4.out_valid);
        check_dut("s8", 7, bus8.out, bus8.cout, bus8.ovf, bus8.out_valid);
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        drv_valid = v;
        drv_a     = a;
        drv_b     = b;
        drv_cin   = c;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        #2;
        check("rst0_s1_out",   int'(bus1.out),       0);
        check("rst0_s1_valid", int'(bus1.out_valid), 0);
        check("rst0_s8_valid", int'(bus8.out_valid), 0);
        repeat (3) tick();
        rst_n = 1'b1;

        drive(1'b1, 8'd14, 8'd15, 1'b0);
        tick();
        check("tp_14p15_out",   int'(bus1.out),       29);
        check("tp_14p15_cout",  int'(bus1.cout),      0);
        check("tp_14p15_ovf",   int'(bus1.ovf),       0);
        check("tp_14p15_valid", int'(bus1.out_valid), 1);
        drive(1'b1, 8'd200, 8'd100, 1'b0);
        tick();
        check("tp_200p100_out",  int'(bus1.out),  44);
        check("tp_200p100_cout", int'(bus1.cout), 1);
        check("tp_200p100_ovf",  int'(bus1.ovf),  0);
        drive(1'b1, 8'hFF, 8'h01, 1'b1);
        tick();
        check("tp_ffp01c_out",  int'(bus1.out),  1);
        check("tp_ffp01c_cout", int'(bus1.cout), 1);
        drive(1'b1, 8'd127, 8'd1, 1'b0);
        tick();
        check("tp_127p1_out",  int'(bus1.out),  128);
        check("tp_127p1_ovf",  int'(bus1.ovf),  1);
        check("tp_127p1_cout", int'(bus1.cout), 0);
        drive(1'b1, 8'h80, 8'h80, 1'b0);
        tick();
        check("tp_80p80_out",  int'(bus1.out),  0);
        check("tp_80p80_cout", int'(bus1.cout), 1);
        check("tp_80p80_ovf",  int'(bus1.ovf),  1);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        repeat (8) tick();

        // Back-to-back stream through the 4-stage instance.
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        drive(1'b1, 8'd10, 8'd10, 1'b0);
        tick();
        drive(1'b1, 8'h55, 8'hAA, 1'b0);
        tick();
        check("s4_stream_pre_valid", int'(bus4.out_valid), 0);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        tick();
        check("s4_stream0_out",   int'(bus4.out),       0);
        check("s4_stream0_cout",  int'(bus4.cout),      1);
        check("s4_stream0_valid", int'(bus4.out_valid), 1);
        tick();
        check("s4_stream1_out",   int'(bus4.out),       20);
        check("s4_stream1_valid", int'(bus4.out_valid), 1);
        tick();
        check("s4_stream2_out",   int'(bus4.out),       8'hFF);
        check("s4_stream2_cout",  int'(bus4.cout),      0);
        check("s4_stream2_valid", int'(bus4.out_valid), 1);
        tick();
        check("s4_stream_post_valid", int'(bus4.out_valid), 0);
        repeat (8) tick();

        // Reset one cycle after issuing 100+27: the pipelined result must never appear.
        drive(1'b1, 8'd100, 8'd27, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        tick();
        rst_n        = 1'b0;
        last_rst_cyc = cyc;
        #1;
        check("midrst_s4_valid", int'(bus4.out_valid), 0);
        check("midrst_s4_out",   int'(bus4.out),       0);
        check("midrst_s8_valid", int'(bus8.out_valid), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // Valid gaps 1,0,1.
        drive(1'b1, 8'd1, 8'd2, 1'b0);
        tick();
        check("gap_s1_a_out",   int'(bus1.out),       3);
        check("gap_s1_a_valid", int'(bus1.out_valid), 1);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        tick();
        check("gap_s1_hole_valid", int'(bus1.out_valid), 0);
        drive(1'b1, 8'd3, 8'd4, 1'b0);
        tick();
        check("gap_s1_b_out", int'(bus1.out), 7);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        repeat (5) tick();
        check("gap_s8_a_out",   int'(bus8.out),       3);
        check("gap_s8_a_valid", int'(bus8.out_valid), 1);
        tick();
        check("gap_s8_hole_valid", int'(bus8.out_valid), 0);
        tick();
        check("gap_s8_b_out",   int'(bus8.out),       7);
        check("gap_s8_b_valid", int'(bus8.out_valid), 1);
        repeat (4) tick();

        // Random traffic with occasional idle cycles.
        repeat (300) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/n_bit_adder.md
Name: n_bit_adder

Overview:
- Registered, optionally carry-segmented two-operand N-bit adder.
- It is the leaf arithmetic cell of the pipelined 16-input adder tree: each tree level instantiates it per operand pair.
- Sum is modulo 2^WIDTH, with carry-out and signed-overflow flags.
- A valid bit travels alongside the data so tree levels stay aligned.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=1).
- STAGES, 1, pipeline depth. The carry chain splits into STAGES segments, with carry registered between segments. Range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- input1  input  WIDTH  operand A, unsigned/two's-complement agnostic.
- input2  input  WIDTH  operand B.
- cin  input  1  carry-in. Tie 0 for plain addition.
- out  output  WIDTH  sum modulo 2^WIDTH.
- cout  output  1  unsigned carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow: operands have the same sign and the sum sign differs.
- out_valid  output  1  out/cout/ovf valid.

Behaviour:
- Reset:
  - rst_n low clears all pipeline registers immediately, without waiting for clk.
  - out=0, cout=0, ovf=0, out_valid=0.
  - Any operation in flight is discarded. No result is emitted for it after release.
- Segmenting:
  - SEG = ceil(WIDTH/STAGES). Segment s covers bits [s*SEG, min((s+1)*SEG, WIDTH)-1].
  - The last segment may be narrower than SEG.
- Stage s (0-based):
  - Adds segment s of the delayed operands plus the carry from stage s-1. Stage 0 uses cin.
  - Registers the segment sum and carry.
  - Higher, not-yet-added operand segments are carried forward in delay registers (skew registers).
  - Lower result segments are delayed so that all result bits emerge together (deskew).
- Latency:
  - Operands sampled at rising edge k with in_valid=1 produce out/cout/ovf/out_valid=1 after edge k+STAGES-1.
  - STAGES=1 gives results directly after the sampling edge.
- Throughput: one operation per cycle. Back-to-back in_valid is fully supported, with no stalls and no backpressure.
- Invalid data:
  - in_valid=0 propagates as out_valid=0.
  - Data registers still load (don't-care contents). out is only meaningful when out_valid=1.
- Arithmetic:
  - {cout,out} = input1 + input2 + cin, exact over WIDTH+1 bits.
  - ovf = (input1[MSB]==input2[MSB]) && (out[MSB]!=input1[MSB]).
- Result is bit-identical for every legal STAGES value. Only latency differs.
- Illegal parameters: STAGES outside 1..WIDTH is a static elaboration error.

Decomposition:
- Shared package adder_pkg:
  - function seg_width(WIDTH, STAGES) returning ceil(WIDTH/STAGES).
  - localparam-friendly helper for segment bounds.
- One natural sub-module: adder_segment. It is a combinational SEG-bit full adder with ports a, b, ci, s, co, instantiated per stage via generate.
- The pipeline, skew and deskew registers live in n_bit_adder.

Test Plan:
- Reset and basic add, WIDTH=8, STAGES=1: hold rst_n=0 -> all outputs 0. Release; input1=14, input2=15, cin=0, in_valid=1 -> one edge later out=29, cout=0, ovf=0, out_valid=1.
- Wrap and carry: 200+100 -> out=44, cout=1, ovf=0. 0xFF+0x01 with cin=1 -> out=0x01, cout=1.
- Signed overflow: 127+1 -> out=128, ovf=1, cout=0. 0x80+0x80 -> out=0, cout=1, ovf=1.
- Pipelined, WIDTH=8, STAGES=4 (2-bit segments):
  - Back-to-back streams 0xFF+0x01, 10+10, 0x55+0xAA.
  - Results 0x00 (cout=1), 20, 0xFF (cout=0) appear on consecutive cycles, starting 3 edges after the first sampling edge, with out_valid high for exactly 3 cycles.
- Reset mid-operation, STAGES=4: assert rst_n low one cycle after issuing 100+27 -> outputs clear immediately. After release, no out_valid pulse ever appears for 100+27.
- Valid gaps: in_valid pattern 1,0,1 with sums 1+2 and 3+4 -> out_valid pattern 1,0,1 with out 3 then 7. The result is unchanged for STAGES=1 and STAGES=8, apart from latency.
